alu_ctrl_dmem: RTL and testbench
================================

# alu_ctrl_dmem

Execution-and-memory core slice of the 8-bit-datapath RV32I-subset pipelined processor. It contains three parts. The first is the combinational main/ALU control decoder, used in the Decode stage. The second is the combinational 8-bit ALU with a zero flag, used in the Execute stage. The third is the 256×8 data memory, used in the Memory stage. Pipeline registers, forwarding muxes, the register file and immediate extension are outside this block.

## Interface
Parameters:
- DEPTH, 256: data memory words. Must equal 2^8 so the 8-bit address never goes out of range.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, named `rst`.
- clk  in  1  memory write clock, rising edge
- rst  in  1  asynchronous, active-low reset; clears the data memory
- op_code  in  7  instruction[6:0]
- func3  in  3  instruction[14:12]
- func7  in  7  instruction[31:25]
- RegWriteD  out  1  register-file write enable
- MemWriteD  out  1  data-memory write enable
- BranchD  out  1  conditional branch (beq)
- ALUSrcD  out  1  1 = immediate is the ALU B operand, 0 = register
- ImmSrcD  out  2  00 I-type, 01 S-type, 10 B-type
- ResultSrcD  out  2  00 ALU result, 01 memory read data, 10 PC+4
- ALUControlD  out  3  ALU operation code
- src_a, src_b  in  8  ALU operands
- ctrl  in  3  ALU operation code
- result  out  8  ALU result
- z  out  1  1 when result == 0
- write_enable  in  1  memory write strobe
- address  in  8  memory address (byte-indexed, one byte per word)
- write_data  in  8  memory write data
- rd  out  8  memory read data

## Operation
- Main decode (the unlisted outputs are 0):
  - lw (0000011): RegWrite=1, ALUSrc=1, ImmSrc=00, ResultSrc=01, ALUOp=add.
  - sw (0100011): MemWrite=1, ALUSrc=1, ImmSrc=01, ALUOp=add.
  - R-type (0110011): RegWrite=1, ALUSrc=0, ALUOp=func.
  - I-ALU (0010011): RegWrite=1, ALUSrc=1, ImmSrc=00, ALUOp=func.
  - beq (1100011): Branch=1, ImmSrc=10, ALUOp=sub.
  - Any other opcode: every output 0, ALUControl=000. This makes it a NOP.
- ALUOp=func decodes from func3:
  - 000: sub if op_code[5] & func7[5], else add.
  - 100: xor.
  - 110: or.
  - 111: and.
  - 010: slt (see Configuration).
  - Any other func3: add.
- ALUControl codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt. Codes 110 and 111 produce result 0.
- Arithmetic is 8-bit with wrap-around; there are no carry or overflow outputs. Examples: 0xFF+0x01=0x00 with z=1; 0x00-0x01=0xFF.
- slt compares signed: result = {7'b0, $signed(a) < $signed(b)}.
- Memory write: on the rising edge of clk, if write_enable and rst=1, mem[address] ← write_data.
- Memory read: combinational, rd = mem[address].
- Reset: rst=0 immediately clears all 256 words to 0x00. Writes during reset are ignored.

## Timing
- Decoder and ALU are purely combinational with zero-cycle latency. There is no internal state.
- Reset value of every output:
  - Decoder and ALU outputs follow their inputs only.
  - rd = 0x00 during and after reset until the first write.
- A write is visible on rd in the same cycle, right after the clock edge (no read latency).
- Read-during-write to the same address: rd shows the old value before the edge and the new value after it.
- Reset asserted in the middle of a write cycle: reset wins and the memory stays at 0.

## Configuration
- ALU_SLT_EN:
  - Defined: func3=010 under ALUOp=func decodes to ALUControl 101, and the ALU implements signed slt.
  - Undefined: func3=010 decodes to add, and code 101 produces result 0.

## Structure
- Shared package alu_ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ);
  - ALUControl codes;
  - ImmSrc and ResultSrc encodings;
  - the ALUOp encoding (00 add, 01 sub, 10 func).
- One sub-module is natural: data_mem, which holds the 256×8 array with async clear.
- The decoder and ALU stay as always_comb blocks in the top module.

## Test plan
- Reset with rst=0, then 1: read addresses 0x00 and 0xFF → rd=0x00 for both. Write 0x5A to address 0x10 → rd=0x5A after the edge. Assert rst=0 → rd=0x00 immediately.
- Decode each opcode:
  - lw → RegWrite=1, ALUSrc=1, ResultSrc=01, ALUControl=000.
  - sw → MemWrite=1, ImmSrc=01.
  - beq → Branch=1, ImmSrc=10, ALUControl=001.
  - opcode 0x7F → all outputs 0.
- R-type with func3=000: func7=0x20 → ALUControl=001. Same func7 with the I-ALU opcode (addi) → ALUControl=000.
- ALU: 0x7F+0x01=0x80 (z=0); 0x05-0x05=0x00 (z=1); 0xF0 & 0x3C=0x30; 0xF0 | 0x0F=0xFF; 0xAA ^ 0xFF=0x55.
- With ALU_SLT_EN: slt 0xFE,0x01 → 0x01, and slt 0x01,0xFE → 0x00. Without the macro, func3=010 decodes to ALUControl 000.
- Write enable held low at a clock edge → memory unchanged. A write attempted while rst=0 → ignored.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the decode/execute/memory slice: opcodes, ALU codes, ALUOp, ImmSrc, ResultSrc.
// func_alu_code() maps func3/func7 to an ALU code; the slt entry depends on `ALU_SLT_EN.
package alu_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } aluop_e;

  // Only R-type (op_code[5]=1) with func7[5] selects sub; addi never subtracts.
  function automatic logic [2:0] func_alu_code(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] code;
    case (f3)
      3'b000:  code = sub_sel ? ALU_SUB : ALU_ADD;
      3'b100:  code = ALU_XOR;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
`ifdef ALU_SLT_EN
      3'b010:  code = ALU_SLT;
`endif
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_ctrl_dmem_data_mem.sv
// 256x8 data memory: combinational read, rising-edge write, asynchronous active-low clear.
// A write is visible on rd right after its edge; reset overrides any write in progress.
module alu_ctrl_dmem_data_mem #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_enable,
  input  logic [7:0] address,
  input  logic [7:0] write_data,
  output logic [7:0] rd
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (write_enable) begin
      r_mem[address] <= write_data;
    end
  end

  assign rd = r_mem[address];

endmodule

// File: rtl/alu_ctrl_dmem.sv
// Decode-stage control decoder, Execute-stage 8-bit ALU and Memory-stage 256x8 data memory.
// Decoder/ALU are zero-latency combinational; `ALU_SLT_EN enables signed slt (func3=010, code 101).
module alu_ctrl_dmem
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic       RegWriteD,
  output logic       MemWriteD,
  output logic       BranchD,
  output logic       ALUSrcD,
  output logic [1:0] ImmSrcD,
  output logic [1:0] ResultSrcD,
  output logic [2:0] ALUControlD,
  input  logic [7:0] src_a,
  input  logic [7:0] src_b,
  input  logic [2:0] ctrl,
  output logic [7:0] result,
  output logic       z,
  input  logic       write_enable,
  input  logic [7:0] address,
  input  logic [7:0] write_data,
  output logic [7:0] rd
);

  aluop_e w_alu_op;
  logic   w_unused;

  assign w_unused = ^{func7[6], func7[4:0]};

  always_comb begin
    RegWriteD  = 1'b0;
    MemWriteD  = 1'b0;
    BranchD    = 1'b0;
    ALUSrcD    = 1'b0;
    ImmSrcD    = IMM_I;
    ResultSrcD = RES_ALU;
    w_alu_op   = ALUOP_ADD;
    case (op_code)
      OP_LW: begin
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        ImmSrcD    = IMM_I;
        ResultSrcD = RES_MEM;
      end
      OP_SW: begin
        MemWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        ImmSrcD   = IMM_S;
      end
      OP_R: begin
        RegWriteD = 1'b1;
        w_alu_op  = ALUOP_FUNC;
      end
      OP_I: begin
        RegWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        w_alu_op  = ALUOP_FUNC;
      end
      OP_BEQ: begin
        BranchD  = 1'b1;
        ImmSrcD  = IMM_B;
        w_alu_op = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControlD = ALU_ADD;
    case (w_alu_op)
      ALUOP_SUB:  ALUControlD = ALU_SUB;
      ALUOP_FUNC: ALUControlD = func_alu_code(func3, op_code[5] & func7[5]);
      default:    ALUControlD = ALU_ADD;
    endcase
  end

  always_comb begin
    result = 8'h00;
    case (ctrl)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_XOR: result = src_a ^ src_b;
`ifdef ALU_SLT_EN
      ALU_SLT: result = {7'b0, $signed(src_a) < $signed(src_b)};
`endif
      default: result = 8'h00;
    endcase
  end

  assign z = (result == 8'h00);

  alu_ctrl_dmem_data_mem #(
    .DEPTH(DEPTH)
  ) u_data_mem (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .rd           (rd)
  );

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Randomized self-checking bench for alu_ctrl_dmem against a behavioural model.
module tb_alu_ctrl_dmem;

  logic       clk;
  logic       rst;
  logic [6:0] op_code;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       RegWriteD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0] ImmSrcD, ResultSrcD;
  logic [2:0] ALUControlD;
  logic [7:0] src_a, src_b;
  logic [2:0] ctrl;
  logic [7:0] result;
  logic       z;
  logic       write_enable;
  logic [7:0] address, write_data;
  logic [7:0] rd;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] m_mem [256];
  logic [10:0] dec_v;

  alu_ctrl_dmem #(.DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .op_code(op_code), .func3(func3), .func7(func7),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ImmSrcD(ImmSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .src_a(src_a), .src_b(src_b), .ctrl(ctrl), .result(result), .z(z),
    .write_enable(write_enable), .address(address), .write_data(write_data), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dec_v = {RegWriteD, MemWriteD, BranchD, ALUSrcD, ImmSrcD, ResultSrcD, ALUControlD};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Decoder reference: {RegWrite, MemWrite, Branch, ALUSrc, ImmSrc, ResultSrc, ALUControl}
  function automatic logic [10:0] model_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    int fn;
    if (f3 == 3'd0) fn = (op[5] && f7[5]) ? 1 : 0;
    else if (f3 == 3'd4) fn = 4;
    else if (f3 == 3'd6) fn = 3;
    else if (f3 == 3'd7) fn = 2;
`ifdef ALU_SLT_EN
    else if (f3 == 3'd2) fn = 5;
`endif
    else fn = 0;
    if (op == 7'h03) return 11'b1_0_0_1_00_01_000;
    if (op == 7'h23) return 11'b0_1_0_1_01_00_000;
    if (op == 7'h33) return {8'b1_0_0_0_00_00, 3'(fn)};
    if (op == 7'h13) return {8'b1_0_0_1_00_00, 3'(fn)};
    if (op == 7'h63) return 11'b0_0_1_0_10_00_001;
    return 11'b0;
  endfunction

  function automatic int model_alu(input int a, input int b, input int c);
    int sa, sb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (c)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
`ifdef ALU_SLT_EN
      5: return (sa < sb) ? 1 : 0;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic dec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [10:0] exp);
    op_code = op; func3 = f3; func7 = f7;
    #1;
    check(tag, 32'(dec_v), 32'(exp));
  endtask

  task automatic alu(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] c, input logic [7:0] exp);
    src_a = a; src_b = b; ctrl = c;
    #1;
    check(tag, 32'(result), 32'(exp));
    check({tag, "_z"}, 32'(z), 32'(exp == 8'h00));
  endtask

  initial begin
    logic [6:0] ops [6];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h00};
    rst = 1'b0; write_enable = 1'b0; address = 8'h00; write_data = 8'h00;
    op_code = 7'h00; func3 = 3'h0; func7 = 7'h00; src_a = 8'h00; src_b = 8'h00; ctrl = 3'h0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    // Reset behaviour and writes ignored under reset
    #2;
    check("rst_rd00", 32'(rd), 32'h00);
    address = 8'hFF; #1;
    check("rst_rdFF", 32'(rd), 32'h00);
    @(negedge clk);
    write_enable = 1'b1; address = 8'h10; write_data = 8'h77;
    @(posedge clk); #1;
    check("wr_in_rst", 32'(rd), 32'h00);
    @(negedge clk);
    write_enable = 1'b0; rst = 1'b1;
    address = 8'h00; #1;
    check("post_rst00", 32'(rd), 32'h00);
    address = 8'hFF; #1;
    check("post_rstFF", 32'(rd), 32'h00);

    @(negedge clk);
    write_enable = 1'b1; address = 8'h10; write_data = 8'h5A; #1;
    check("rdw_old", 32'(rd), 32'h00);
    @(posedge clk); #1;
    check("wr_5A", 32'(rd), 32'h5A);
    @(negedge clk);
    write_enable = 1'b0; write_data = 8'hC3;
    @(posedge clk); #1;
    check("we_low", 32'(rd), 32'h5A);
    @(negedge clk);
    #2 rst = 1'b0; #1;
    check("async_clr", 32'(rd), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    write_enable = 1'b1; write_data = 8'h99;
    @(posedge clk); #1;
    check("wr_99", 32'(rd), 32'h99);
    @(negedge clk);
    write_data = 8'h11; #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_wr", 32'(rd), 32'h00);
    @(negedge clk);
    rst = 1'b1; write_enable = 1'b0;

    // Randomized memory traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      write_enable = ($urandom_range(0, 2) != 0);
      address      = 8'($urandom_range(0, 31));
      write_data   = 8'($urandom);
      #1;
      check("mem_pre", 32'(rd), 32'(m_mem[address]));
      @(posedge clk);
      if (write_enable) m_mem[address] = write_data;
      #1;
      check("mem_post", 32'(rd), 32'(m_mem[address]));
    end
    write_enable = 1'b0;

    // Directed decode
    dec("lw",      7'h03, 3'h2, 7'h00, 11'b1_0_0_1_00_01_000);
    dec("sw",      7'h23, 3'h2, 7'h00, 11'b0_1_0_1_01_00_000);
    dec("beq",     7'h63, 3'h0, 7'h00, 11'b0_0_1_0_10_00_001);
    dec("nop7F",   7'h7F, 3'h7, 7'h7F, 11'b0);
    dec("r_sub",   7'h33, 3'h0, 7'h20, 11'b1_0_0_0_00_00_001);
    dec("r_add",   7'h33, 3'h0, 7'h00, 11'b1_0_0_0_00_00_000);
    dec("addi",    7'h13, 3'h0, 7'h20, 11'b1_0_0_1_00_00_000);
    dec("r_xor",   7'h33, 3'h4, 7'h00, 11'b1_0_0_0_00_00_100);
    dec("r_or",    7'h33, 3'h6, 7'h00, 11'b1_0_0_0_00_00_011);
    dec("i_and",   7'h13, 3'h7, 7'h00, 11'b1_0_0_1_00_00_010);
    dec("r_f3_1",  7'h33, 3'h1, 7'h00, 11'b1_0_0_0_00_00_000);
`ifdef ALU_SLT_EN
    dec("r_slt",   7'h33, 3'h2, 7'h00, 11'b1_0_0_0_00_00_101);
`else
    dec("r_slt",   7'h33, 3'h2, 7'h00, 11'b1_0_0_0_00_00_000);
`endif
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = (i % 7 == 6) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      dec("dec_rand", op, f3, f7, model_dec(op, f3, f7));
    end

    // Directed ALU
    alu("add7F",  8'h7F, 8'h01, 3'd0, 8'h80);
    alu("addwrap",8'hFF, 8'h01, 3'd0, 8'h00);
    alu("sub55",  8'h05, 8'h05, 3'd1, 8'h00);
    alu("subwrap",8'h00, 8'h01, 3'd1, 8'hFF);
    alu("and",    8'hF0, 8'h3C, 3'd2, 8'h30);
    alu("or",     8'hF0, 8'h0F, 3'd3, 8'hFF);
    alu("xor",    8'hAA, 8'hFF, 3'd4, 8'h55);
    alu("code6",  8'h12, 8'h34, 3'd6, 8'h00);
    alu("code7",  8'hFF, 8'hFF, 3'd7, 8'h00);
`ifdef ALU_SLT_EN
    alu("slt_neg", 8'hFE, 8'h01, 3'd5, 8'h01);
    alu("slt_pos", 8'h01, 8'hFE, 3'd5, 8'h00);
`else
    alu("code5",   8'hFE, 8'h01, 3'd5, 8'h00);
`endif
    for (int i = 0; i < 300; i++) begin
      int a, b, c;
      a = $urandom_range(0, 255);
      b = (i % 5 == 0) ? a : $urandom_range(0, 255);
      c = $urandom_range(0, 7);
      alu("alu_rand", 8'(a), 8'(b), 3'(c), 8'(model_alu(a, b, c)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
